// File: rtl/axi_mem_responder.sv
// axi_mem_responder: single-port AXI-style slave backed by a 2^MEM_ADDR_WIDTH x 32-bit word store.
// Latency: first R beat READ_LATENCY+1 cycles after the AR handshake; writes take one cycle per beat.
// Backpressure: one burst at a time; R/B hold until RREADY/BREADY; AW wins over AR in IDLE.
//
// Optional feature macro: MEM_RESP_STALL_EN (LFSR-driven random WREADY / R-beat stalls).
//
// Ports:
//   i_clk, i_rst                     clock, synchronous active-high reset
//   i_aw* / o_awready                write address channel (LEN is the beat count, 0 means 1)
//   i_w*  / o_wready                 write data channel (i_wid is ignored)
//   o_bvalid, o_bid / i_bready       write response channel
//   i_ar* / o_arready                read address channel
//   o_r*  / i_rready                 read data channel
//   o_protocol_err                   sticky: WLAST disagreed with the LEN count on an accepted beat

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module axi_mem_responder #(
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    // write address
    input  logic                   i_awvalid,
    output logic                   o_awready,
    input  logic [3:0]             i_awid,
    input  logic [4:0]             i_awlen,
    input  logic [`ADDR_WIDTH-1:0] i_awaddr,
    // write data
    input  logic                   i_wvalid,
    output logic                   o_wready,
    input  logic [3:0]             i_wid,
    input  logic [`DATA_WIDTH-1:0] i_wdata,
    input  logic                   i_wlast,
    // write response
    output logic                   o_bvalid,
    input  logic                   i_bready,
    output logic [3:0]             o_bid,
    // read address
    input  logic                   i_arvalid,
    output logic                   o_arready,
    input  logic [3:0]             i_arid,
    input  logic [`ADDR_WIDTH-1:0] i_araddr,
    input  logic [4:0]             i_arlen,
    // read data
    output logic                   o_rvalid,
    input  logic                   i_rready,
    output logic [3:0]             o_rid,
    output logic [`DATA_WIDTH-1:0] o_rdata,
    output logic                   o_rlast,
    // status
    output logic                   o_protocol_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        R_WAIT = 3'd1,
        R_DATA = 3'd2,
        W_DATA = 3'd3,
        W_RESP = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [3:0]                r_id;
    logic [4:0]                r_len;      // beats in burst, 1..16
    logic [4:0]                r_beat;     // beats already completed
    logic [MEM_ADDR_WIDTH-1:0] r_idx;
    logic [3:0]                r_lat;
    logic                      r_perr;

    logic [`DATA_WIDTH-1:0]    r_mem [0:(1<<MEM_ADDR_WIDTH)-1];

    logic                      w_last_beat;
    logic                      w_w_fire;
    logic                      w_r_fire;
    logic                      w_wr_stall;
    logic                      w_rd_stall;
    logic [MEM_ADDR_WIDTH-1:0] w_aw_idx;
    logic [MEM_ADDR_WIDTH-1:0] w_ar_idx;
    logic [4:0]                w_aw_len;
    logic [4:0]                w_ar_len;
    logic                      w_unused_bits;

    // Only the word-index bits of the addresses matter; the rest alias.
    assign w_aw_idx = i_awaddr[MEM_ADDR_WIDTH+1:2];
    assign w_ar_idx = i_araddr[MEM_ADDR_WIDTH+1:2];
    assign w_aw_len = (i_awlen == 5'd0) ? 5'd1 : i_awlen;
    assign w_ar_len = (i_arlen == 5'd0) ? 5'd1 : i_arlen;
    assign w_unused_bits = ^{i_wid, i_awaddr, i_araddr};

    assign w_last_beat = ((r_beat + 5'd1) == r_len);
    assign w_w_fire    = i_wvalid & o_wready;
    assign w_r_fire    = o_rvalid & i_rready;

`ifdef MEM_RESP_STALL_EN
    logic [15:0] r_lfsr;
    logic        r_rshown;   // current R beat is already on the bus and must stay there

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr   <= 16'hACE1;
            r_rshown <= 1'b0;
        end else begin
            // x^16 + x^14 + x^13 + x^11 + 1, Fibonacci form shifting right
            r_lfsr   <= {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
            r_rshown <= (r_state == R_DATA) && o_rvalid && !i_rready;
        end
    end

    assign w_wr_stall = r_lfsr[0];
    assign w_rd_stall = r_lfsr[0] & ~r_rshown;
`else
    assign w_wr_stall = 1'b0;
    assign w_rd_stall = 1'b0;
`endif

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_awvalid)      w_state_nxt = W_DATA;
                else if (i_arvalid) w_state_nxt = R_WAIT;
            end
            R_WAIT: if (r_lat == 4'd0)              w_state_nxt = R_DATA;
            R_DATA: if (w_r_fire && w_last_beat)    w_state_nxt = IDLE;
            W_DATA: if (w_w_fire && w_last_beat)    w_state_nxt = W_RESP;
            W_RESP: if (i_bready)                   w_state_nxt = IDLE;
            default:                                w_state_nxt = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        o_awready = 1'b0;
        o_arready = 1'b0;
        o_wready  = 1'b0;
        o_bvalid  = 1'b0;
        o_bid     = 4'd0;
        o_rvalid  = 1'b0;
        o_rid     = 4'd0;
        o_rdata   = '0;
        o_rlast   = 1'b0;
        case (r_state)
            IDLE: begin
                o_awready = ~i_rst;
                o_arready = ~i_rst & ~i_awvalid;
            end
            R_DATA: begin
                o_rvalid = ~w_rd_stall;
                o_rid    = r_id;
                o_rdata  = r_mem[r_idx];
                o_rlast  = w_last_beat;
            end
            W_DATA: o_wready = ~w_wr_stall;
            W_RESP: begin
                o_bvalid = 1'b1;
                o_bid    = r_id;
            end
            default: ;
        endcase
    end

    assign o_protocol_err = r_perr;

    // Burst bookkeeping
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_id   <= 4'd0;
            r_len  <= 5'd0;
            r_beat <= 5'd0;
            r_idx  <= '0;
            r_lat  <= 4'd0;
            r_perr <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_beat <= 5'd0;
                    if (i_awvalid) begin
                        r_id  <= i_awid;
                        r_len <= w_aw_len;
                        r_idx <= w_aw_idx;
                    end else if (i_arvalid) begin
                        r_id  <= i_arid;
                        r_len <= w_ar_len;
                        r_idx <= w_ar_idx;
                        // counts down to 0, giving READ_LATENCY cycles in R_WAIT
                        r_lat <= 4'(READ_LATENCY - 1);
                    end
                end
                R_WAIT: begin
                    if (r_lat != 4'd0) r_lat <= r_lat - 4'd1;
                end
                R_DATA: begin
                    if (w_r_fire) begin
                        r_idx  <= r_idx + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
                        r_beat <= r_beat + 5'd1;
                    end
                end
                W_DATA: begin
                    if (w_w_fire) begin
                        r_idx  <= r_idx + {{(MEM_ADDR_WIDTH-1){1'b0}}, 1'b1};
                        r_beat <= r_beat + 5'd1;
                        if (i_wlast != w_last_beat) r_perr <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Backing store: never reset
    always_ff @(posedge i_clk) begin
        if (!i_rst && (r_state == W_DATA) && w_w_fire) begin
            r_mem[r_idx] <= i_wdata;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_axi_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        awvalid, awready;
    logic [3:0]  awid;
    logic [4:0]  awlen;
    logic [31:0] awaddr;
    logic        wvalid, wready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid, bready;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [4:0]  arlen;
    logic        rvalid, rready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic        rlast;
    logic        perr;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    logic [31:0] exp_d [0:15];

    always #5 clk = ~clk;

    axi_mem_responder dut (
        .i_clk(clk), .i_rst(rst),
        .i_awvalid(awvalid), .o_awready(awready), .i_awid(awid), .i_awlen(awlen), .i_awaddr(awaddr),
        .i_wvalid(wvalid), .o_wready(wready), .i_wid(wid), .i_wdata(wdata), .i_wlast(wlast),
        .o_bvalid(bvalid), .i_bready(bready), .o_bid(bid),
        .i_arvalid(arvalid), .o_arready(arready), .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen),
        .o_rvalid(rvalid), .i_rready(rready), .o_rid(rid), .o_rdata(rdata), .o_rlast(rlast),
        .o_protocol_err(perr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // All bus tasks are entered and left 1 time unit after a rising edge.
    task automatic aw_phase(input logic [31:0] addr, input logic [4:0] len, input logic [3:0] id);
        int cnt;
        awaddr = addr; awlen = len; awid = id; awvalid = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!awready && cnt < 20) begin
            @(posedge clk); #1; @(negedge clk); cnt++;
        end
        chk("aw_accept", awready, 1);
        chk("ar_blocked_by_aw", arready, 0);
        @(posedge clk); #1;
        awvalid = 1'b0;
    endtask

    task automatic w_phase(input int nb, input logic [31:0] base, input int wlast_beat);
        int cnt;
        for (int b = 0; b < nb; b++) begin
            wvalid = 1'b1; wdata = base + b; wlast = (b + 1 == wlast_beat); wid = 4'hF;
            cnt = 0;
            @(negedge clk);
            while (!wready && cnt < 20) begin
                @(posedge clk); #1; @(negedge clk); cnt++;
            end
            chk("w_accept", wready, 1);
            chk("ar_rdy_in_wdata", arready, 0);
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic b_phase(input logic [3:0] id);
        int cnt;
        cnt = 0;
        @(negedge clk);
        while (!bvalid && cnt < 20) begin
            @(posedge clk); #1; @(negedge clk); cnt++;
        end
        chk("b_vld", bvalid, 1);
        chk("b_id", bid, id);
        chk("aw_rdy_in_bresp", awready, 0);
        chk("ar_rdy_in_bresp", arready, 0);
        bready = 1'b1;
        @(posedge clk); #1;
        bready = 1'b0;
        chk("b_vld_clr", bvalid, 0);
    endtask

    // rst_at / hold_at: 1-based beat on which to reset / drop RREADY for one cycle (0 = never)
    task automatic rd_burst(input logic [31:0] addr, input logic [4:0] len, input logic [3:0] id,
                            input int rst_at, input int hold_at);
        int cnt;
        int nb;
        nb = (len == 5'd0) ? 1 : int'(len);
        araddr = addr; arlen = len; arid = id; arvalid = 1'b1;
        cnt = 0;
        @(negedge clk);
        while (!arready && cnt < 50) begin
            @(posedge clk); #1; @(negedge clk); cnt++;
        end
        chk("ar_accept", arready, 1);
        @(posedge clk); #1;
        arvalid = 1'b0; rready = 1'b1;
        cnt = 0;
        do begin
            @(negedge clk); cnt++;
        end while (!rvalid && cnt < 50);
        chk("r_first_latency", cnt, 5);
        for (int b = 0; b < nb; b++) begin
            chk("r_vld", rvalid, 1);
            chk("r_data", rdata, exp_d[b]);
            chk("r_last", rlast, (b == nb - 1));
            chk("r_id", rid, id);
            if (b + 1 == rst_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                @(negedge clk);
                chk("r_vld_after_rst", rvalid, 0);
                chk("idle_after_rst", arready, 1);
                rready = 1'b0;
                @(posedge clk); #1;
                return;
            end
            if (b + 1 == hold_at) begin
                rready = 1'b0;
                @(posedge clk); #1; @(negedge clk);
                chk("r_hold_vld", rvalid, 1);
                chk("r_hold_data", rdata, exp_d[b]);
                chk("r_hold_last", rlast, (b == nb - 1));
                rready = 1'b1;
            end
            @(posedge clk); #1;
            if (b < nb - 1) @(negedge clk);
        end
        rready = 1'b0;
        chk("r_vld_end", rvalid, 0);
    endtask

    initial begin
        rst = 1'b1;
        awvalid = 0; awid = 0; awlen = 0; awaddr = 0;
        wvalid = 0; wid = 0; wdata = 0; wlast = 0;
        bready = 0;
        arvalid = 0; arid = 0; araddr = 0; arlen = 0;
        rready = 0;

        // Reset state: READY low while rst is held, even with requests pending
        repeat (2) @(posedge clk);
        #1;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_perr", perr, 0);
        awvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_awready", awready, 1);
        chk("idle_arready", arready, 1);
        @(posedge clk); #1;

        // Clean 4-beat write at 0x100
        aw_phase(32'h100, 5'd4, 4'h3);
        w_phase(4, 32'hA0, 4);
        b_phase(4'h3);
        chk("perr_clean_write", perr, 0);

        // Read it back, plain and with one RREADY stall on beat 2
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
        rd_burst(32'h100, 5'd4, 4'h8, 0, 0);
        rd_burst(32'h103, 5'd4, 4'h1, 0, 2);   // byte-offset bits ignored

        // High address bits alias: 0x40100 -> word 0x40 (same as 0x100)
        exp_d[0] = 32'hA0;
        rd_burst(32'h40100, 5'd1, 4'h2, 0, 0);

        // AW and AR together: write wins, read waits and sees the new data
        araddr = 32'h200; arlen = 5'd2; arid = 4'h6; arvalid = 1'b1;
        aw_phase(32'h200, 5'd2, 4'h5);
        w_phase(2, 32'hB0, 2);
        b_phase(4'h5);
        exp_d[0] = 32'hB0; exp_d[1] = 32'hB1;
        rd_burst(32'h200, 5'd2, 4'h6, 0, 0);

        // Wrap from the last word index to word 0
        aw_phase(32'h3FFFC, 5'd2, 4'h1);
        w_phase(2, 32'hC0, 2);
        b_phase(4'h1);
        exp_d[0] = 32'hC1;
        rd_burst(32'h0, 5'd1, 4'h4, 0, 0);
        exp_d[0] = 32'hC0; exp_d[1] = 32'hC1;
        rd_burst(32'h3FFFC, 5'd2, 4'h4, 0, 0);

        // LEN 0 means a single beat
        aw_phase(32'h400, 5'd0, 4'h2);
        w_phase(1, 32'hD0, 1);
        b_phase(4'h2);
        chk("perr_len0", perr, 0);
        exp_d[0] = 32'hD0;
        rd_burst(32'h400, 5'd0, 4'hC, 0, 0);

        // Early WLAST: error is sticky, burst still runs to 4 beats
        aw_phase(32'h300, 5'd4, 4'h7);
        w_phase(4, 32'hE0, 2);
        b_phase(4'h7);
        chk("perr_set", perr, 1);
        exp_d[0] = 32'hE0; exp_d[1] = 32'hE1; exp_d[2] = 32'hE2; exp_d[3] = 32'hE3;
        rd_burst(32'h300, 5'd4, 4'h7, 0, 0);
        chk("perr_sticky", perr, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("perr_cleared", perr, 0);
        @(posedge clk); #1;

        // Reset during read beat 2, then a normal read; memory survives reset
        exp_d[0] = 32'hA0; exp_d[1] = 32'hA1; exp_d[2] = 32'hA2; exp_d[3] = 32'hA3;
        rd_burst(32'h100, 5'd4, 4'h9, 2, 0);
        rd_burst(32'h100, 5'd2, 4'hA, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
